// File: rtl/rgb2hsv_pipe.sv
// rgb2hsv_pipe: free-running RGB -> HSV pipeline, one pixel per clock,
// fixed latency L = DW+4 for data, syncs and data-enable alike.
// Hue is {sector[2:0], frac[DW-1:0]}; saturation and hue fraction come from
// two pipelined restoring dividers that resolve one quotient bit per stage.
// Optional feature: define HSI_INTENSITY_EN to output intensity floor((R+G+B)/3)
// on V_data instead of max(R,G,B).
module rgb2hsv_pipe #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            RGB_hsync,
    input  logic            RGB_vsync,
    input  logic [3*DW-1:0] RGB_data,
    input  logic            RGB_de,
    output logic            HSV_hsync,
    output logic            HSV_vsync,
    output logic [DW+2:0]   H_data,
    output logic [DW-1:0]   S_data,
    output logic [DW-1:0]   V_data,
    output logic            HSV_de
);

    localparam int L = DW + 4;

    // One restoring-division step: returns {quotient_bit, new_remainder}.
    // The trial value is below 2*divisor, so the remainder always fits DW bits.
    function automatic logic [DW:0] div_step(input logic [DW:0] trial,
                                             input logic [DW-1:0] dv);
        logic [DW:0] diff;
        diff = trial - {1'b0, dv};
        if (trial >= {1'b0, dv}) begin
            return {1'b1, DW'(diff)};
        end else begin
            return {1'b0, DW'(trial)};
        end
    endfunction

    // ------------------------------------------------------------------
    // Sync / de delay lines, kept apart from the data path
    // ------------------------------------------------------------------
    logic [L-1:0] hs_q, vs_q, de_q;

    // Shift syncs and de through L-deep delay lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q <= '0;
            vs_q <= '0;
            de_q <= '0;
        end else begin
            hs_q <= {hs_q[L-2:0], RGB_hsync};
            vs_q <= {vs_q[L-2:0], RGB_vsync};
            de_q <= {de_q[L-2:0], RGB_de};
        end
    end

    assign HSV_hsync = hs_q[L-1];
    assign HSV_vsync = vs_q[L-1];
    assign HSV_de    = de_q[L-1];

    // ------------------------------------------------------------------
    // Stage 1: ordering, sector, chroma
    // ------------------------------------------------------------------
    logic [DW-1:0] r_s, g_s, b_s;
    logic [DW-1:0] max_s, mid_s, min_s;
    logic [2:0]    sec_s;

    assign r_s = RGB_data[3*DW-1:2*DW];
    assign g_s = RGB_data[2*DW-1:DW];
    assign b_s = RGB_data[DW-1:0];

    // Classify the pixel into a sector (first match wins) and sort channels.
    always_comb begin
        max_s = r_s;
        mid_s = g_s;
        min_s = b_s;
        sec_s = 3'd0;
        if (r_s >= g_s && g_s >= b_s) begin
            max_s = r_s; mid_s = g_s; min_s = b_s; sec_s = 3'd0;
        end else if (g_s > r_s && r_s >= b_s) begin
            max_s = g_s; mid_s = r_s; min_s = b_s; sec_s = 3'd1;
        end else if (g_s >= b_s && b_s > r_s) begin
            max_s = g_s; mid_s = b_s; min_s = r_s; sec_s = 3'd2;
        end else if (b_s > g_s && g_s > r_s) begin
            max_s = b_s; mid_s = g_s; min_s = r_s; sec_s = 3'd3;
        end else if (b_s > r_s && r_s >= g_s) begin
            max_s = b_s; mid_s = r_s; min_s = g_s; sec_s = 3'd4;
        end else begin
            max_s = r_s; mid_s = b_s; min_s = g_s; sec_s = 3'd5;
        end
    end

    logic [DW-1:0] s1_max_q, s1_mid_q, s1_min_q, s1_d_q;
    logic [2:0]    s1_sec_q;
`ifdef HSI_INTENSITY_EN
    logic [DW+1:0] s1_sum_q;
`endif

    // Register stage-1 results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_max_q <= '0;
            s1_mid_q <= '0;
            s1_min_q <= '0;
            s1_d_q   <= '0;
            s1_sec_q <= 3'd0;
`ifdef HSI_INTENSITY_EN
            s1_sum_q <= '0;
`endif
        end else begin
            s1_max_q <= max_s;
            s1_mid_q <= mid_s;
            s1_min_q <= min_s;
            s1_d_q   <= max_s - min_s;
            s1_sec_q <= sec_s;
`ifdef HSI_INTENSITY_EN
            s1_sum_q <= {2'b00, r_s} + {2'b00, g_s} + {2'b00, b_s};
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: hue numerator, divisors, value/intensity
    // ------------------------------------------------------------------
    logic [DW-1:0] hnum_s, v_s;

    // Odd sectors measure hue downward from max, even sectors upward from min.
    always_comb begin
        if (s1_sec_q[0]) begin
            hnum_s = s1_max_q - s1_mid_q;
        end else begin
            hnum_s = s1_mid_q - s1_min_q;
        end
    end

`ifdef HSI_INTENSITY_EN
    // Reciprocal of 3 scaled so that (sum*K)>>(DW+4) is exact floor(sum/3).
    localparam logic [DW+2:0] THIRD_K = (DW+3)'(((1 << (DW + 4)) + 2) / 3);
    logic [2*DW+4:0] prod_s;
    assign prod_s = {{(DW+3){1'b0}}, s1_sum_q} * {{(DW+2){1'b0}}, THIRD_K};
    assign v_s    = DW'(prod_s >> (DW + 4));
`else
    assign v_s    = s1_max_q;
`endif

    logic [DW-1:0] s2_hnum_q, s2_d_q, s2_max_q, s2_v_q;
    logic [2:0]    s2_sec_q;

    // Register stage-2 operands for both dividers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_hnum_q <= '0;
            s2_d_q    <= '0;
            s2_max_q  <= '0;
            s2_v_q    <= '0;
            s2_sec_q  <= 3'd0;
        end else begin
            s2_hnum_q <= hnum_s;
            s2_d_q    <= s1_d_q;
            s2_max_q  <= s1_max_q;
            s2_v_q    <= v_s;
            s2_sec_q  <= s1_sec_q;
        end
    end

    // ------------------------------------------------------------------
    // Stages 3..DW+3: two restoring dividers, DW+1 quotient bits
    // ------------------------------------------------------------------
    logic [DW-1:0] hr_q  [0:DW];
    logic [DW-1:0] hdv_q [0:DW];
    logic [DW:0]   hq_q  [0:DW];
    logic [DW-1:0] sr_q  [0:DW];
    logic [DW-1:0] sdv_q [0:DW];
    logic [DW:0]   sq_q  [0:DW];
    logic [2:0]    sec_q [0:DW];
    logic [DW-1:0] vp_q  [0:DW];
    logic [DW:0]   hstep_s [0:DW];
    logic [DW:0]   sstep_s [0:DW];

    // First step compares the unshifted numerator (the 2^DW quotient bit);
    // later steps shift the partial remainder left by one.
    always_comb begin
        hstep_s[0] = div_step({1'b0, s2_hnum_q}, s2_d_q);
        sstep_s[0] = div_step({1'b0, s2_d_q}, s2_max_q);
        for (int k = 1; k <= DW; k++) begin
            hstep_s[k] = div_step({hr_q[k-1], 1'b0}, hdv_q[k-1]);
            sstep_s[k] = div_step({sr_q[k-1], 1'b0}, sdv_q[k-1]);
        end
    end

    // Advance each divider stage together with its own operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= DW; k++) begin
                hr_q[k]  <= '0;
                hdv_q[k] <= '0;
                hq_q[k]  <= '0;
                sr_q[k]  <= '0;
                sdv_q[k] <= '0;
                sq_q[k]  <= '0;
                sec_q[k] <= 3'd0;
                vp_q[k]  <= '0;
            end
        end else begin
            hr_q[0]  <= hstep_s[0][DW-1:0];
            hq_q[0]  <= {{DW{1'b0}}, hstep_s[0][DW]};
            hdv_q[0] <= s2_d_q;
            sr_q[0]  <= sstep_s[0][DW-1:0];
            sq_q[0]  <= {{DW{1'b0}}, sstep_s[0][DW]};
            sdv_q[0] <= s2_max_q;
            sec_q[0] <= s2_sec_q;
            vp_q[0]  <= s2_v_q;
            for (int k = 1; k <= DW; k++) begin
                hr_q[k]  <= hstep_s[k][DW-1:0];
                hq_q[k]  <= {hq_q[k-1][DW-1:0], hstep_s[k][DW]};
                hdv_q[k] <= hdv_q[k-1];
                sr_q[k]  <= sstep_s[k][DW-1:0];
                sq_q[k]  <= {sq_q[k-1][DW-1:0], sstep_s[k][DW]};
                sdv_q[k] <= sdv_q[k-1];
                sec_q[k] <= sec_q[k-1];
                vp_q[k]  <= vp_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Final stage: saturation, zero-divisor handling, blanking
    // ------------------------------------------------------------------
    logic [DW-1:0] hfrac_s, ssat_s;

    // A zero divisor yields 0; a quotient of exactly 2^DW clips to all-ones.
    always_comb begin
        if (hdv_q[DW] == {DW{1'b0}}) begin
            hfrac_s = {DW{1'b0}};
        end else if (hq_q[DW][DW]) begin
            hfrac_s = {DW{1'b1}};
        end else begin
            hfrac_s = hq_q[DW][DW-1:0];
        end
        if (sdv_q[DW] == {DW{1'b0}}) begin
            ssat_s = {DW{1'b0}};
        end else if (sq_q[DW][DW]) begin
            ssat_s = {DW{1'b1}};
        end else begin
            ssat_s = sq_q[DW][DW-1:0];
        end
    end

    // Register outputs; data is forced to zero whenever the aligned de is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            H_data <= '0;
            S_data <= '0;
            V_data <= '0;
        end else if (de_q[L-2]) begin
            H_data <= {sec_q[DW], hfrac_s};
            S_data <= ssat_s;
            V_data <= vp_q[DW];
        end else begin
            H_data <= '0;
            S_data <= '0;
            V_data <= '0;
        end
    end

endmodule
